p2s_feeder: RTL

Upstream feeder for the 8-bit `parallel_to_serial` shifter. It accepts bytes over a valid/ready handshake and buffers them in a small FIFO. It drives the shifter's `load` and `parallel_in` so consecutive bytes leave `serial_out` as a gap-free bit stream, LSB first. It also holds `parallel_in` stable for the whole 8-cycle frame, because the shifter reloads bit 7 from `parallel_in[7]` on every clock.

---
 rtl/p2s_pkg.sv | 17 +
 rtl/p2s_feeder_if.sv | 28 ++
 rtl/p2s_sync_fifo.sv | 60 ++++++
 rtl/p2s_feeder.sv | 108 ++++++++++
 4 files changed

// File: rtl/p2s_pkg.sv
// p2s_pkg: shared constants and types for the p2s_feeder block.
//   DATA_W         byte width handed to the parallel_to_serial shifter
//   FRAME_LEN      shifter clocks per byte (one bit per clock)
//   BIT_CNT_W      width of the in-frame bit counter
//   feeder_state_t feeder FSM encoding (IDLE / SHIFT)
package p2s_pkg;

    localparam int DATA_W    = 8;
    localparam int FRAME_LEN = 8;
    localparam int BIT_CNT_W = $clog2(FRAME_LEN);

    typedef enum logic {
        IDLE,
        SHIFT
    } feeder_state_t;

endpackage

// File: rtl/p2s_feeder_if.sv
// p2s_feeder_if: upstream byte handshake into p2s_feeder.
//   in_valid  producer has a byte on in_data
//   in_data   the byte (DATA_W bits)
//   in_ready  feeder can take a byte this cycle
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready.
// While in_valid is high and in_ready low, the producer holds in_data stable;
// in_ready does not depend combinationally on in_valid.
interface p2s_feeder_if
    import p2s_pkg::*;
();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/p2s_sync_fifo.sv
// p2s_sync_fifo: single-clock FIFO with the head word visible on rdata.
//   clk, rst_n  clock and asynchronous active-low reset (flushes pointers)
//   push, wdata write wdata at the tail (ignored when full)
//   pop         discard the head (ignored when empty)
//   rdata       current head word, valid whenever !empty
//   full, empty occupancy flags, decoded from registered pointers
module p2s_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage needs no reset: a flushed FIFO never exposes stale words.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/p2s_feeder.sv
// p2s_feeder: buffers upstream bytes and feeds an 8-bit parallel_to_serial
// shifter so consecutive bytes leave serial_out gap-free, LSB first.
//   clk, rst_n    clock (shared with the shifter), async active-low reset
//   up            upstream byte handshake (slave side)
//   load          one-cycle pulse to shifter load
//   parallel_out  shifter parallel_in; held for the whole frame and in IDLE
//   busy          a frame is being serialised (state == SHIFT)
//   frames_sent   number of loads issued, wrapping
//   state_dbg     current FSM state
module p2s_feeder
    import p2s_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    p2s_feeder_if.slave          up,
    output logic                 load,
    output logic [DATA_W-1:0]    parallel_out,
    output logic                 busy,
    output logic [CNT_W-1:0]     frames_sent,
    output feeder_state_t        state_dbg
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_LEN - 1);

    feeder_state_t        state;
    logic [BIT_CNT_W-1:0] bit_cnt;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              push;
    logic              pop;
    logic              frame_end;

    assign push        = up.in_valid && up.in_ready;
    assign up.in_ready = !fifo_full;

    // The last bit of a frame is the only point inside SHIFT where the next
    // byte may be loaded; loading there keeps the bit stream gap-free.
    assign frame_end = (state == SHIFT) && (bit_cnt == LAST_BIT);
    assign pop       = !fifo_empty && ((state == IDLE) || frame_end);

    p2s_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (up.in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            load         <= 1'b0;
            parallel_out <= '0;
            busy         <= 1'b0;
            frames_sent  <= '0;
        end else begin
            load <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state        <= SHIFT;
                        busy         <= 1'b1;
                        load         <= 1'b1;
                        parallel_out <= fifo_rdata;
                        bit_cnt      <= '0;
                        frames_sent  <= frames_sent + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                SHIFT: begin
                    if (frame_end) begin
                        if (pop) begin
                            load         <= 1'b1;
                            parallel_out <= fifo_rdata;
                            bit_cnt      <= '0;
                            frames_sent  <= frames_sent + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            // parallel_out is left alone so the shifter keeps
                            // re-injecting the last byte's bit 7 while idle.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + {{(BIT_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule
